// File: rtl/data_bus_master.sv
// data_bus_master
//   Bus-master front end between the pipeline memory stage and the data bus
//   decoder. Takes one load/store at a time from the pipeline, drives the bus
//   strobes/address/data (all registered) until DataDone, returns the result,
//   forces one strobe-low RECOVER cycle between transactions and aborts hung
//   transactions after TIMEOUT_CYCLES cycles in ACCESS (0 = no timeout).
//
// Ports
//   Clock, Reset            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready     pipeline request handshake
//   req_we, req_addr,       request: 1=store/0=load, address, store data
//   req_wdata
//   resp_valid, resp_rdata, one-cycle completion pulse, load data, timeout flag
//   resp_err
//   busy                    high whenever the master is not IDLE
//   ReadData, WriteData     bus read/write strobes
//   DataAddr, BusIn         bus address and write data
//   BusOut, DataDone        bus read data and completion
//   err_count               saturating count of timeouts
//   state_dbg               current FSM state (0=IDLE, 1=ACCESS, 2=RECOVER)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_* are sampled only on that edge. req_ready does
// not depend on req_valid. resp_valid is a single-cycle pulse with no
// back-pressure; resp_rdata and resp_err are meaningful only while it is high.

module data_bus_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        ReadData,
  output logic        WriteData,
  output logic [15:0] DataAddr,
  output logic [15:0] BusIn,
  input  logic [15:0] BusOut,
  input  logic        DataDone,
  output logic [7:0]  err_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam bit             TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int             TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_d, wr_d, rv_d, rerr_d;
  logic [15:0]      addr_d, wdata_d, rdata_d;
  logic [7:0]       errc_d;

  logic accept, done_hit, to_hit;

  assign req_ready = (state_q != S_ACCESS);
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;
  assign accept    = req_valid & req_ready;
  // DataDone outranks the timeout when both land on the same edge.
  assign done_hit  = (state_q == S_ACCESS) & DataDone;
  assign to_hit    = (state_q == S_ACCESS) & ~DataDone & TO_EN & (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = accept ? S_ACCESS : S_IDLE;
      S_ACCESS:  state_d = (done_hit || to_hit) ? S_RECOVER : S_ACCESS;
      S_RECOVER: state_d = accept ? S_ACCESS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus/response outputs.
  always_comb begin
    cnt_d   = cnt_q;
    rd_d    = ReadData;
    wr_d    = WriteData;
    addr_d  = DataAddr;
    wdata_d = BusIn;
    rv_d    = 1'b0;
    rdata_d = resp_rdata;
    rerr_d  = resp_err;
    errc_d  = err_count;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wr_d    = req_we;
      rd_d    = ~req_we;
      cnt_d   = '0;
    end else if (state_q == S_ACCESS) begin
      if (DataDone) begin
        // ReadData is held for all of ACCESS, so it identifies a load.
        if (ReadData) rdata_d = BusOut;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        rv_d   = 1'b1;
        rerr_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (to_hit) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
          if (err_count != 8'hFF) errc_d = err_count + 8'd1;
        end
      end
    end
  end

  // Registered outputs; reset drops the strobes immediately.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q      <= '0;
      ReadData   <= 1'b0;
      WriteData  <= 1'b0;
      DataAddr   <= '0;
      BusIn      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ReadData   <= rd_d;
      WriteData  <= wr_d;
      DataAddr   <= addr_d;
      BusIn      <= wdata_d;
      resp_valid <= rv_d;
      resp_rdata <= rdata_d;
      resp_err   <= rerr_d;
      err_count  <= errc_d;
    end
  end

endmodule

// File: doc/data_bus_master.md
Name: data_bus_master

Overview:
- Bus-master front end between the pipeline memory stage and the data bus decoder.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Drives the bus request signals ReadData, WriteData, DataAddr and BusIn, and holds them until the bus returns DataDone.
- Returns read data or write completion to the pipeline. Enforces the bus rule that strobes drop for at least one cycle between transactions, and aborts hung transactions with a timeout.

Parameters:
- TIMEOUT_CYCLES, default 256: number of ACCESS cycles without DataDone before abort; 0 disables the timeout.
- CNT_W, default 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  pipeline presents a request.
- req_ready  output  1  master can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  16  bus address ([15:12] device, [11:8] sub-device).
- req_wdata  input  16  store data.
- resp_valid  output  1  one-cycle pulse; transaction finished.
- resp_rdata  output  16  load data; valid with resp_valid.
- resp_err  output  1  with resp_valid: transaction timed out.
- busy  output  1  state != IDLE (pipeline stall source).
- ReadData  output  1  bus read strobe.
- WriteData  output  1  bus write strobe.
- DataAddr  output  16  bus address.
- BusIn  output  16  bus write data.
- BusOut  input  16  bus read data.
- DataDone  input  1  bus completion.
- err_count  output  8  saturating count of timeouts.

Behaviour:
- Reset (Reset=0), asynchronous:
  - state=IDLE.
  - ReadData=WriteData=0, DataAddr=0, BusIn=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, err_count=0, timeout counter=0.
- All bus outputs are registered.
- States: IDLE, ACCESS, RECOVER.
- req_ready=1 in IDLE and RECOVER, 0 in ACCESS.
- busy=1 in ACCESS and RECOVER.
- Accept: at an edge with req_valid & req_ready:
  - latch req_addr into DataAddr and req_wdata into BusIn;
  - set WriteData=req_we, ReadData=~req_we;
  - clear the counter; go to ACCESS.
  - Strobes are therefore high from the next cycle.
- ACCESS, edge with DataDone=1:
  - if a load, resp_rdata<=BusOut; for a store, resp_rdata holds its old value;
  - clear both strobes; resp_valid<=1, resp_err<=0; go to RECOVER.
- ACCESS, edge with DataDone=0:
  - counter increments.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: clear strobes; resp_valid<=1, resp_err<=1, resp_rdata<=0; err_count increments, saturating at 255; go to RECOVER.
  - DataDone=1 takes priority over timeout on the same edge.
- RECOVER:
  - Exactly one cycle with strobes low; DataAddr and BusIn hold.
  - resp_valid is high during this cycle only.
  - Next state: ACCESS if a request is accepted, else IDLE.
  - DataDone during RECOVER is ignored; the memory done flag may still read 1 here.
- DataDone is ignored in IDLE and RECOVER.
- A strobe is never asserted in two consecutive transactions without an intervening low cycle. This is required because the memory done flag toggles while strobes are held.
- Latency, accept-edge to resp_valid:
  - combinational-done device (IO/SW/KEY): 2 cycles;
  - memory: 3 cycles;
  - minimum repeat interval: 3 cycles for IO, 4 for memory.
- DataAddr and BusIn are stable for the whole of ACCESS. req_* inputs are sampled only at the accept edge.
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronous), no response is produced, and the transaction is lost.

Test Plan:
- Load 0x0010 (memory), memory word=0xBEEF → ReadData high 2 cycles; resp_valid 3 cycles after accept; resp_rdata=0xBEEF; resp_err=0.
- Store 0x2200 data 0x03FF (LEDR), DataDone tied 1 → WriteData high exactly 1 cycle; resp_valid 2 cycles after accept; LEDR=0x3FF.
- Back-to-back memory loads 0x0001 then 0x0002 with req_valid held → strobes low one cycle between; both responses carry the correct data; second accept occurs in RECOVER.
- TIMEOUT_CYCLES=4, load 0x1000 with DataDone stuck 0 → strobes high 4 cycles, then resp_valid with resp_err=1, resp_rdata=0; err_count=1.
- DataDone rises on the same edge as timeout expiry → resp_err=0 and data captured.
- Reset pulled low mid-ACCESS → ReadData/WriteData=0 within the same cycle; state IDLE; no resp_valid after release.
